// File: rtl/audio_pkg.sv
// Shared audio definitions: sequencer state encoding, ROM note-word field
// positions, end-of-song marker and audio word width.
package audio_pkg;

  localparam int unsigned AUDIO_W = 12;
  localparam int unsigned ROM_W   = 24;

  // Note word layout: {period[23:12], duration[11:0]}
  localparam int unsigned PER_MSB = 23;
  localparam int unsigned PER_LSB = 12;
  localparam int unsigned DUR_MSB = 11;
  localparam int unsigned DUR_LSB = 0;

  // A duration of zero marks the end of the song.
  localparam logic [AUDIO_W-1:0] END_DUR = '0;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StLoad,
    StPlay
  } seq_state_e;

  function automatic logic [ROM_W-1:0] pack_note(input logic [AUDIO_W-1:0] per,
                                                 input logic [AUDIO_W-1:0] dur);
    return {per, dur};
  endfunction

endpackage

// File: rtl/note_sequencer.sv
// Melody sequencer: walks note words in an external synchronous ROM and drives
// the PWM generator's period/h_time. Each note is held for its duration in
// ticks; the last GAP_TICKS ticks are muted so repeated pitches separate.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, stop      single-cycle playback controls (stop wins over start)
//   loop             level: restart at address 0 on the end marker
//   volume           attenuation, h_time = period >> (1 + volume)
//   tick             one-cycle duration enable
//   rom_addr         registered ROM address
//   rom_data         ROM word, valid one cycle after rom_addr
//   period, h_time   to the PWM generator
//   playing          high whenever not idle
//   done             one-cycle pulse when the song ends without looping
module note_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [1:0]         volume,
  input  logic               tick,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [ROM_W-1:0]   rom_data,
  output logic [AUDIO_W-1:0] period,
  output logic [AUDIO_W-1:0] h_time,
  output logic               playing,
  output logic               done
);

  localparam logic [AUDIO_W-1:0] GapW = AUDIO_W'(GAP_TICKS);

  seq_state_e         state;
  logic [AUDIO_W-1:0] remaining;

  logic [AUDIO_W-1:0] rom_per;
  logic [AUDIO_W-1:0] rom_dur;
  logic [AUDIO_W-1:0] h_load;
  logic [AUDIO_W-1:0] rem_dec;

  always_comb begin
    rom_per = rom_data[PER_MSB:PER_LSB];
    rom_dur = rom_data[DUR_MSB:DUR_LSB];
    h_load  = rom_per >> (3'd1 + {1'b0, volume});
    rem_dec = remaining - 12'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      rom_addr  <= '0;
      period    <= '0;
      h_time    <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state     <= StIdle;
        playing   <= 1'b0;
        period    <= '0;
        h_time    <= '0;
        remaining <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            period <= '0;
            h_time <= '0;
            if (start) begin
              rom_addr <= '0;
              playing  <= 1'b1;
              state    <= StFetch;
            end
          end
          // ROM registers the word at rom_addr during this cycle.
          StFetch: state <= StLoad;
          StLoad: begin
            if (rom_dur == END_DUR) begin
              if (loop) begin
                rom_addr <= '0;
                state    <= StFetch;
              end else begin
                done    <= 1'b1;
                playing <= 1'b0;
                period  <= '0;
                h_time  <= '0;
                state   <= StIdle;
              end
            end else begin
              period    <= rom_per;
              remaining <= rom_dur;
              // Notes no longer than the gap are silent throughout.
              h_time    <= (rom_dur > GapW) ? h_load : '0;
              state     <= StPlay;
            end
          end
          StPlay: begin
            if (tick) begin
              remaining <= rem_dec;
              if (rem_dec <= GapW) h_time <= '0;
              if (remaining == 12'd1) begin
                rom_addr <= rom_addr + 1'b1;  // wraps naturally
                state    <= StFetch;
              end
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
  import audio_pkg::*;

  localparam int SigPeriod = 0;
  localparam int SigHTime  = 1;
  localparam int SigPlay   = 2;
  localparam int SigDone   = 3;
  localparam int SigAddr   = 4;
  localparam int SigWAddr  = 5;
  localparam int SigWDone  = 6;
  localparam int SigWPlay  = 7;

  typedef struct {
    string tag;
    int    sig;
    int    exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, loop = 1'b0, tick = 1'b0;
  logic        start_w = 1'b0;
  logic [1:0]  volume = 2'd0;

  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic [11:0] period, h_time;
  logic        playing, done;

  logic [1:0]  w_addr;
  logic [23:0] w_data;
  logic [11:0] w_period, w_h_time;
  logic        w_playing, w_done;

  logic [23:0] rom   [256];
  logic [23:0] rom_w [4];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  note_sequencer #(.ADDR_W(8), .GAP_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .volume(volume), .tick(tick), .rom_addr(rom_addr), .rom_data(rom_data),
    .period(period), .h_time(h_time), .playing(playing), .done(done)
  );

  note_sequencer #(.ADDR_W(2), .GAP_TICKS(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .stop(stop), .loop(1'b0),
    .volume(2'd0), .tick(tick), .rom_addr(w_addr), .rom_data(w_data),
    .period(w_period), .h_time(w_h_time), .playing(w_playing), .done(w_done)
  );

  // Synchronous ROM models.
  always @(posedge clk) begin
    rom_data <= rom[rom_addr];
    w_data   <= rom_w[w_addr];
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int observe(input int sig);
    case (sig)
      SigPeriod: return int'(period);
      SigHTime:  return int'(h_time);
      SigPlay:   return int'(playing);
      SigDone:   return int'(done);
      SigAddr:   return int'(rom_addr);
      SigWAddr:  return int'(w_addr);
      SigWDone:  return int'(w_done);
      default:   return int'(w_playing);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input int exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Compare every queued expectation against the DUT as it stands now.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    loop = 1'b0;
    cyc(1);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  initial begin
    clear_rom();
    for (int i = 0; i < 4; i++) rom_w[i] = pack_note(12'd100, 12'd1);

    // Reset state
    #3;
    expect_val("rst_period", SigPeriod, 0);
    expect_val("rst_htime", SigHTime, 0);
    expect_val("rst_playing", SigPlay, 0);
    expect_val("rst_done", SigDone, 0);
    expect_val("rst_addr", SigAddr, 0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Basic note {478,5} then end marker, tick every 10 cycles
    rom[0] = pack_note(12'd478, 12'd5);
    pulse_start();
    expect_val("e0_playing", SigPlay, 1);
    expect_val("e0_addr", SigAddr, 0);
    drain();
    cyc(2);
    expect_val("e2_period", SigPeriod, 478);
    expect_val("e2_htime", SigHTime, 239);
    drain();
    for (int t = 1; t <= 5; t++) begin
      cyc(9);
      do_tick();
      if (t == 2) expect_val("tick2_htime", SigHTime, 239);
      if (t == 3) expect_val("tick3_htime", SigHTime, 0);
      if (t == 3) expect_val("tick3_period", SigPeriod, 478);
      drain();
    end
    expect_val("fetch_addr", SigAddr, 1);
    expect_val("fetch_period_held", SigPeriod, 478);
    expect_val("fetch_done", SigDone, 0);
    drain();
    cyc(1);
    expect_val("load_done", SigDone, 0);
    expect_val("load_playing", SigPlay, 1);
    drain();
    cyc(1);
    expect_val("end_done", SigDone, 1);
    expect_val("end_playing", SigPlay, 0);
    expect_val("end_period", SigPeriod, 0);
    drain();
    cyc(1);
    expect_val("done_one_cycle", SigDone, 0);
    drain();

    // Volume: sampled at load, held mid-note
    clear_rom();
    rom[0] = pack_note(12'd800, 12'd3);
    rom[1] = pack_note(12'd800, 12'd3);
    volume = 2'd2;
    pulse_start();
    cyc(2);
    expect_val("vol2_htime", SigHTime, 100);
    drain();
    volume = 2'd0;
    cyc(3);
    expect_val("vol_held", SigHTime, 100);
    drain();
    repeat (3) do_tick();
    cyc(2);
    expect_val("vol0_htime", SigHTime, 400);
    expect_val("vol0_period", SigPeriod, 800);
    drain();
    // stop mid-PLAY
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    expect_val("stop_period", SigPeriod, 0);
    expect_val("stop_htime", SigHTime, 0);
    expect_val("stop_playing", SigPlay, 0);
    expect_val("stop_done", SigDone, 0);
    drain();
    cyc(2);
    expect_val("stop_nodone", SigDone, 0);
    drain();

    // Short note and rest
    clear_rom();
    rom[0] = pack_note(12'd600, 12'd2);
    rom[1] = pack_note(12'd0, 12'd4);
    pulse_start();
    cyc(2);
    expect_val("short_period", SigPeriod, 600);
    expect_val("short_htime", SigHTime, 0);
    drain();
    do_tick();
    expect_val("short_htime_t1", SigHTime, 0);
    drain();
    do_tick();
    cyc(2);
    for (int t = 1; t <= 3; t++) begin
      expect_val("rest_period", SigPeriod, 0);
      expect_val("rest_htime", SigHTime, 0);
      expect_val("rest_playing", SigPlay, 1);
      drain();
      do_tick();
    end
    do_tick();
    cyc(2);
    expect_val("rest_end_done", SigDone, 1);
    drain();
    cyc(1);

    // Loop
    clear_rom();
    rom[0] = pack_note(12'd300, 12'd1);
    loop = 1'b1;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      cyc(2);
      expect_val("loop_period", SigPeriod, 300);
      expect_val("loop_addr0", SigAddr, 0);
      drain();
      do_tick();
      expect_val("loop_addr1", SigAddr, 1);
      drain();
      cyc(2);
      expect_val("loop_addr_back", SigAddr, 0);
      expect_val("loop_nodone", SigDone, 0);
      expect_val("loop_playing", SigPlay, 1);
      drain();
    end
    halt();

    // start and stop together in IDLE
    stop = 1'b1;
    start = 1'b1;
    cyc(1);
    stop = 1'b0;
    start = 1'b0;
    expect_val("startstop_playing", SigPlay, 0);
    drain();
    cyc(3);
    expect_val("startstop_idle", SigPlay, 0);
    expect_val("startstop_period", SigPeriod, 0);
    drain();

    // Asynchronous reset mid-PLAY
    clear_rom();
    rom[0] = pack_note(12'd478, 12'd5);
    rom[1] = pack_note(12'd478, 12'd5);
    pulse_start();
    cyc(2);
    do_tick();
    repeat (4) do_tick();
    cyc(2);
    expect_val("pre_rst_addr", SigAddr, 1);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("arst_period", SigPeriod, 0);
    expect_val("arst_htime", SigHTime, 0);
    expect_val("arst_playing", SigPlay, 0);
    expect_val("arst_addr", SigAddr, 0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Address wrap on a 2-bit address sequencer, tick every cycle
    tick = 1'b1;
    start_w = 1'b1;
    cyc(1);
    start_w = 1'b0;
    expect_val("wrap_addr0", SigWAddr, 0);
    drain();
    for (int k = 1; k <= 4; k++) begin
      cyc(3);
      expect_val("wrap_addr", SigWAddr, k % 4);
      expect_val("wrap_nodone", SigWDone, 0);
      expect_val("wrap_playing", SigWPlay, 1);
      drain();
    end
    tick = 1'b0;
    halt();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays a melody stored in an external synchronous ROM by driving the `period`/`h_time` inputs of the audio PWM generator. Steps through note words, holds each note for a programmed number of ticks, and inserts a short silent gap at the end of each note so repeated pitches are audible. It sits between the game-side audio control (start/stop/loop/volume) and the PWM generator.

## Interface
- `ADDR_W`, 8: ROM address width; the song occupies addresses 0 … 2^ADDR_W−1.
- `GAP_TICKS`, 2: number of trailing ticks of each note that are muted (h_time forced to 0).
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin playback from address 0.
- `stop` in 1: single-cycle request to abort playback.
- `loop` in 1: level signal; when high at the end marker, restart from address 0 instead of finishing.
- `volume` in 2: attenuation; h_time = period >> (1 + volume); sampled at each note load.
- `tick` in 1: one-cycle duration enable, for example 1 ms; counted only in PLAY.
- `rom_addr` out ADDR_W: registered ROM address.
- `rom_data` in 24: ROM word, valid one cycle after `rom_addr`. Bits [23:12] are the period and bits [11:0] are the duration in ticks.
- `period` out 12: to the PWM generator.
- `h_time` out 12: to the PWM generator.
- `playing` out 1: high whenever the FSM is not IDLE.
- `done` out 1: one-cycle pulse when the song ends without looping.

## Operation
- Reset values: state=IDLE; `rom_addr`=0; `period`=0; `h_time`=0; `playing`=0; `done`=0; remaining=0.
- **IDLE**: `period`=0 and `h_time`=0. When `start`=1, set `rom_addr`=0 and go to FETCH.
- **FETCH**: one cycle. The ROM registers the word at `rom_addr`. Go to LOAD.
- **LOAD**: sample `rom_data`.
  - Duration field = 0 is the end marker:
    - If `loop`=1, set `rom_addr`=0 and go to FETCH.
    - Otherwise pulse `done`, zero `period`/`h_time`, and go to IDLE.
  - Any other duration:
    - `period`←data[23:12].
    - h_reg←data[23:12] >> (1+`volume`).
    - remaining←duration.
    - `h_time`←(duration > GAP_TICKS) ? h_reg : 0.
    - Go to PLAY.
- **PLAY**: on `tick`, remaining decrements.
  - On the edge where the new remaining ≤ GAP_TICKS, `h_time`←0. `period` is held.
  - A tick that arrives with remaining=1 advances `rom_addr`←`rom_addr`+1 and goes to FETCH.
- Rest note: period field = 0 gives `period`=0 and `h_time`=0 for the whole duration.
- Address wrap: `rom_addr` wraps from 2^ADDR_W−1 to 0 and playback continues. No end is implied.
- `tick` during FETCH or LOAD is ignored.
- `stop`=1 in any state: go to IDLE on the next edge and zero `period`/`h_time`. `done` is not pulsed.
- `stop` and `start` asserted together: `stop` wins.
- `start` outside IDLE is ignored.
- Reset mid-note: all outputs return to their reset values immediately (asynchronously).

## Timing
- `start` sampled at edge E0:
  - `playing`=1 and `rom_addr`=0 after E0.
  - FETCH during E0→E1, LOAD during E1→E2.
  - `period`/`h_time` valid after E2.
- Note change: the final tick is sampled at edge T. The new `period` appears after T+2. The old `period` is held during FETCH/LOAD. There is a 2-cycle inter-note overhead that is not counted in the duration.
- `done` is high for exactly the one cycle after the LOAD edge that sees the end marker. `playing` falls on that same edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `audio_pkg` contains:
  - The state encoding (IDLE, FETCH, LOAD, PLAY).
  - ROM field positions: `PER_MSB`=23, `PER_LSB`=12, `DUR_MSB`=11, `DUR_LSB`=0.
  - The `END_DUR`=0 constant.
  - The 12-bit audio word width.
- No sub-module. The tick divider lives at the top level and is shared with other audio blocks.

## Test plan
- Basic note with GAP_TICKS=2, volume=0.
  - Stimulus: ROM[0]={478,5}, ROM[1]={0,0}; pulse `start`; a tick every 10 cycles.
  - Required response:
    - `period`=478 and `h_time`=239 from E2.
    - `h_time`=0 after the third tick.
    - `done` pulses after the fifth tick plus 2 cycles.
    - `playing`=0 afterwards.
- Volume.
  - Stimulus: volume=2, ROM[0]={800,3}.
  - Required response: `h_time`=100.
  - Then change volume to 0 mid-note: `h_time` stays 100 until the next note load.
- Short note and rest.
  - Stimulus: ROM[0]={600,2}, i.e. duration ≤ GAP_TICKS.
  - Required response: `h_time`=0 for the whole note.
  - Stimulus: ROM[1]={0,4}.
  - Required response: `period`=0 and `h_time`=0 for 4 ticks.
- Loop.
  - Stimulus: `loop`=1; ROM[0]={300,1}, ROM[1]={0,0}.
  - Required response: `rom_addr` sequence 0,1,0,1…; `done` never pulses; `playing` stays 1.
- Stop and start.
  - Stimulus: `stop` and `start` together in IDLE.
    - Required response: stays IDLE.
  - Stimulus: `stop` mid-PLAY.
    - Required response: `period`=0 and `playing`=0 next cycle; no `done`.
  - Stimulus: `rst_n` low mid-PLAY.
    - Required response: immediate reset values.
- Wrap.
  - Stimulus: ADDR_W=2, ROM[0..3] all {100,1}, tick every cycle.
  - Required response: `rom_addr` 0,1,2,3,0 with no `done`.
